// File: rtl/alu_uart_sequencer.sv
// Sequencer between register file, ALU and UART TX: loads operands and a function mask,
// runs each selected ALU function in ascending order and sends each result low byte first.
module alu_uart_sequencer #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned ADDR        = 4,
    parameter int unsigned ALU_FUN_WD  = 4,
    parameter int unsigned ALU_TIMEOUT = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CONTROL_EN,
    output logic                  RF_RdEn,
    output logic [ADDR-1:0]       RF_Address,
    input  logic [WIDTH-1:0]      RF_RdData,
    output logic [WIDTH-1:0]      ALU_A,
    output logic [WIDTH-1:0]      ALU_B,
    output logic                  ALU_EN,
    output logic [ALU_FUN_WD-1:0] ALU_FUN,
    input  logic [2*WIDTH-1:0]    ALU_OUT,
    input  logic                  ALU_OUT_VLD,
    output logic [WIDTH-1:0]      TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_BUSY,
    output logic                  SEQ_BUSY,
    output logic                  SEQ_DONE,
    output logic                  SEQ_ERR
);

    localparam int unsigned NumFun = 2 * WIDTH;
    localparam int unsigned IdxW   = ALU_FUN_WD + 1;
    localparam int unsigned TmrW   = $clog2(ALU_TIMEOUT + 1);

    typedef enum logic [3:0] {
        StIdle, StRdA, StRdB, StRdC0, StRdC1, StScan, StAluReq, StAluWait,
        StTxLo, StTxLoWt, StTxHi, StTxHiWt, StDone
    } state_e;

    state_e                  state_q;
    logic                    ctrl_prev_q;
    logic                    rf_rden_q;
    logic [ADDR-1:0]         rf_addr_q;
    logic                    rd_pend_q;
    logic [1:0]              rd_idx_q;
    logic [WIDTH-1:0]        a_q, b_q;
    logic [NumFun-1:0]       mask_q;
    logic [IdxW-1:0]         idx_q;
    logic [ALU_FUN_WD-1:0]   cur_q;
    logic                    alu_en_q;
    logic [TmrW-1:0]         tmr_q;
    logic [2*WIDTH-1:0]      res_q;
    logic [WIDTH-1:0]        tx_data_q;
    logic                    tx_vld_q;
    logic                    busy_q, done_q, err_q;

    logic                    start;
    logic                    scan_hit;
    logic [ALU_FUN_WD-1:0]   scan_idx;

    assign start = CONTROL_EN & ~ctrl_prev_q;

    // Lowest pending function at or above the current index.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < NumFun; i++) begin
            if (!scan_hit && mask_q[i] && (IdxW'(i) >= idx_q)) begin
                scan_hit = 1'b1;
                scan_idx = ALU_FUN_WD'(i);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StIdle;
            ctrl_prev_q <= 1'b0;
            rf_rden_q   <= 1'b0;
            rf_addr_q   <= '0;
            rd_pend_q   <= 1'b0;
            rd_idx_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mask_q      <= '0;
            idx_q       <= '0;
            cur_q       <= '0;
            alu_en_q    <= 1'b0;
            tmr_q       <= '0;
            res_q       <= '0;
            tx_data_q   <= '0;
            tx_vld_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ctrl_prev_q <= CONTROL_EN;
            // Read data arrives one cycle after the strobe; slot follows the strobed address.
            rd_pend_q   <= rf_rden_q;
            rd_idx_q    <= rf_addr_q[1:0];
            if (rd_pend_q) begin
                case (rd_idx_q)
                    2'd0:    a_q                    <= RF_RdData;
                    2'd1:    b_q                    <= RF_RdData;
                    2'd2:    mask_q[WIDTH-1:0]      <= RF_RdData;
                    default: mask_q[NumFun-1:WIDTH] <= RF_RdData;
                endcase
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        err_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        idx_q     <= '0;
                        rf_rden_q <= 1'b1;
                        rf_addr_q <= ADDR'(0);
                        state_q   <= StRdA;
                    end
                end
                StRdA: begin
                    rf_addr_q <= ADDR'(1);
                    state_q   <= StRdB;
                end
                StRdB: begin
                    rf_addr_q <= ADDR'(2);
                    state_q   <= StRdC0;
                end
                StRdC0: begin
                    rf_addr_q <= ADDR'(3);
                    state_q   <= StRdC1;
                end
                StRdC1: begin
                    rf_rden_q <= 1'b0;
                    if (rd_pend_q && rd_idx_q == 2'd3) begin
                        state_q <= StScan;
                    end
                end
                StScan: begin
                    if (!CONTROL_EN || !scan_hit) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cur_q    <= scan_idx;
                        alu_en_q <= 1'b1;
                        state_q  <= StAluReq;
                    end
                end
                StAluReq: begin
                    alu_en_q <= 1'b0;
                    tmr_q    <= '0;
                    state_q  <= StAluWait;
                end
                StAluWait: begin
                    if (ALU_OUT_VLD) begin
                        res_q     <= ALU_OUT;
                        tx_data_q <= ALU_OUT[WIDTH-1:0];
                        tx_vld_q  <= 1'b1;
                        state_q   <= StTxLo;
                    end else if (tmr_q == TmrW'(ALU_TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        idx_q   <= IdxW'(cur_q) + IdxW'(1);
                        state_q <= StScan;
                    end else begin
                        tmr_q <= tmr_q + TmrW'(1);
                    end
                end
                StTxLo: begin
                    if (TX_BUSY) begin
                        tx_vld_q <= 1'b0;
                        state_q  <= StTxLoWt;
                    end
                end
                StTxLoWt: begin
                    if (!TX_BUSY) begin
                        tx_data_q <= res_q[2*WIDTH-1:WIDTH];
                        tx_vld_q  <= 1'b1;
                        state_q   <= StTxHi;
                    end
                end
                StTxHi: begin
                    if (TX_BUSY) begin
                        tx_vld_q <= 1'b0;
                        state_q  <= StTxHiWt;
                    end
                end
                StTxHiWt: begin
                    if (!TX_BUSY) begin
                        mask_q[cur_q] <= 1'b0;
                        idx_q         <= IdxW'(cur_q) + IdxW'(1);
                        state_q       <= StScan;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign RF_RdEn    = rf_rden_q;
    assign RF_Address = rf_addr_q;
    assign ALU_A      = a_q;
    assign ALU_B      = b_q;
    assign ALU_EN     = alu_en_q;
    assign ALU_FUN    = cur_q;
    assign TX_P_DATA  = tx_data_q;
    assign TX_D_VLD   = tx_vld_q;
    assign SEQ_BUSY   = busy_q;
    assign SEQ_DONE   = done_q;
    assign SEQ_ERR    = err_q;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed bench for alu_uart_sequencer with register-file, ALU and UART TX models.
module tb_alu_uart_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        CONTROL_EN = 1'b0;
    logic        RF_RdEn;
    logic [3:0]  RF_Address;
    logic [7:0]  RF_RdData = 8'h00;
    logic [7:0]  ALU_A, ALU_B;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_OUT = 16'h0000;
    logic        ALU_OUT_VLD = 1'b0;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_BUSY;
    logic        SEQ_BUSY, SEQ_DONE, SEQ_ERR;

    alu_uart_sequencer dut (
        .CLK(CLK), .RST(RST), .CONTROL_EN(CONTROL_EN),
        .RF_RdEn(RF_RdEn), .RF_Address(RF_Address), .RF_RdData(RF_RdData),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
        .SEQ_BUSY(SEQ_BUSY), .SEQ_DONE(SEQ_DONE), .SEQ_ERR(SEQ_ERR)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int n_done = 0;
    int busy_cnt = 0;
    int long_at = -1;
    int long_len = 40;
    bit withhold2 = 1'b0;
    bit watch_hold = 1'b0;
    logic [7:0] hold_byte = 8'h00;
    int n_hold = 0;
    int n_bad = 0;
    logic [7:0] rf_mem [4];
    logic [3:0] rd_q [$];
    logic [3:0] fun_q [$];
    logic [7:0] tx_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] f);
        if (f == 4'd0) return {8'h00, a} + {8'h00, b};
        return {4'h0, f, a ^ b};
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) if (RF_RdEn) RF_RdData <= rf_mem[RF_Address[1:0]];

    always @(posedge CLK) begin
        ALU_OUT_VLD <= 1'b0;
        if (ALU_EN && !(withhold2 && ALU_FUN == 4'd2)) begin
            ALU_OUT_VLD <= 1'b1;
            ALU_OUT     <= alu_f(ALU_A, ALU_B, ALU_FUN);
        end
    end

    assign TX_BUSY = (busy_cnt != 0);

    always @(posedge CLK) begin
        if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        if (TX_D_VLD && !TX_BUSY) busy_cnt <= (tx_q.size() - 1 == long_at) ? long_len : 3;
        if (!RST) busy_cnt <= 0;
    end

    // Monitors sample on the falling edge, half a cycle away from DUT updates.
    always @(negedge CLK) begin
        if (RF_RdEn) rd_q.push_back(RF_Address);
        if (ALU_EN) fun_q.push_back(ALU_FUN);
        if (TX_D_VLD && !TX_BUSY) tx_q.push_back(TX_P_DATA);
        if (SEQ_DONE) begin
            n_done++;
            done_cyc = cyc;
        end
        if (watch_hold && TX_BUSY && tx_q.size() == 1) begin
            n_hold++;
            if ((n_hold > 1 && TX_D_VLD) || TX_P_DATA != hold_byte) n_bad++;
        end
    end

    task automatic clear_logs();
        rd_q.delete();
        fun_q.delete();
        tx_q.delete();
        n_done = 0;
        n_hold = 0;
        n_bad  = 0;
    endtask

    task automatic set_regs(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c0, input logic [7:0] c1);
        rf_mem[0] = a;
        rf_mem[1] = b;
        rf_mem[2] = c0;
        rf_mem[3] = c1;
    endtask

    task automatic start_run();
        @(negedge CLK);
        CONTROL_EN = 1'b1;
        start_cyc  = cyc + 1;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge CLK);
            if (n_done != 0) seen = 1'b1;
        end
        if (!seen) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic finish_run();
        @(negedge CLK);
        CONTROL_EN = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    function automatic logic [15:0] pack_rd();
        logic [15:0] v = 16'h0;
        foreach (rd_q[i]) v = {v[11:0], rd_q[i]};
        return v;
    endfunction

    function automatic logic [63:0] all_outs();
        return {26'h0, RF_RdEn, RF_Address, ALU_A, ALU_B, ALU_EN, ALU_FUN, TX_P_DATA, TX_D_VLD,
                SEQ_BUSY, SEQ_DONE, SEQ_ERR};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        set_regs(8'h0D, 8'h0C, 8'h01, 8'h00);
        repeat (3) @(negedge CLK);
        check("reset_outputs", all_outs(), 64'h0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // Single add: 0x0D + 0x0C
        clear_logs();
        start_run();
        wait_done("t1", 200);
        check("t1_rd_count", rd_q.size(), 4);
        check("t1_rd_addrs", pack_rd(), 16'h0123);
        check("t1_alu_a", ALU_A, 8'h0D);
        check("t1_alu_b", ALU_B, 8'h0C);
        check("t1_fun_count", fun_q.size(), 1);
        if (fun_q.size() > 0) check("t1_fun0", fun_q[0], 4'd0);
        check("t1_tx_count", tx_q.size(), 2);
        if (tx_q.size() == 2) begin
            check("t1_tx_lo", tx_q[0], 8'h19);
            check("t1_tx_hi", tx_q[1], 8'h00);
        end
        check("t1_err", SEQ_ERR, 1'b0);
        finish_run();
        check("t1_done_count", n_done, 1);
        check("t1_idle_busy", SEQ_BUSY, 1'b0);

        // All sixteen functions
        clear_logs();
        set_regs(8'h0D, 8'h0C, 8'hFF, 8'hFF);
        start_run();
        wait_done("t2", 3000);
        check("t2_fun_count", fun_q.size(), 16);
        for (int k = 0; k < fun_q.size() && k < 16; k++) check("t2_fun_seq", fun_q[k], k);
        check("t2_tx_count", tx_q.size(), 32);
        if (tx_q.size() == 32) begin
            check("t2_f3_lo", tx_q[6], 8'h01);
            check("t2_f3_hi", tx_q[7], 8'h03);
            check("t2_f15_hi", tx_q[31], 8'h0F);
        end
        finish_run();
        check("t2_done_count", n_done, 1);

        // Empty mask
        clear_logs();
        set_regs(8'h0D, 8'h0C, 8'h00, 8'h00);
        start_run();
        wait_done("t3", 200);
        check("t3_done_latency", done_cyc - start_cyc, 6);
        check("t3_rd_count", rd_q.size(), 4);
        check("t3_alu_en", fun_q.size(), 0);
        check("t3_tx_count", tx_q.size(), 0);
        finish_run();

        // Function 2 never answers
        clear_logs();
        withhold2 = 1'b1;
        set_regs(8'h0D, 8'h0C, 8'h07, 8'h00);
        start_run();
        wait_done("t4", 500);
        check("t4_err", SEQ_ERR, 1'b1);
        check("t4_fun_count", fun_q.size(), 3);
        check("t4_tx_count", tx_q.size(), 4);
        if (tx_q.size() == 4) begin
            check("t4_f1_lo", tx_q[2], 8'h01);
            check("t4_f1_hi", tx_q[3], 8'h01);
        end
        finish_run();
        withhold2 = 1'b0;
        check("t4_err_sticky", SEQ_ERR, 1'b1);

        // Long UART busy on first byte, enable dropped mid-function
        clear_logs();
        set_regs(8'h0D, 8'h0C, 8'h03, 8'h00);
        long_at    = 0;
        long_len   = 40;
        hold_byte  = 8'h19;
        watch_hold = 1'b1;
        start_run();
        for (int i = 0; i < 200 && tx_q.size() == 0; i++) @(negedge CLK);
        repeat (5) @(negedge CLK);
        CONTROL_EN = 1'b0;
        wait_done("t5", 500);
        watch_hold = 1'b0;
        long_at    = -1;
        check("t5_err_cleared", SEQ_ERR, 1'b0);
        check("t5_hold_cycles", n_hold, 40);
        check("t5_hold_bad", n_bad, 0);
        check("t5_tx_count", tx_q.size(), 2);
        if (tx_q.size() == 2) check("t5_tx_hi", tx_q[1], 8'h00);
        check("t5_fun_count", fun_q.size(), 1);
        finish_run();

        // Reset while waiting for the high byte to drain
        clear_logs();
        set_regs(8'h0D, 8'h0C, 8'h01, 8'h00);
        long_at = 1;
        start_run();
        for (int i = 0; i < 200 && tx_q.size() < 2; i++) @(negedge CLK);
        repeat (5) @(negedge CLK);
        check("t6_busy_before_rst", SEQ_BUSY, 1'b1);
        RST = 1'b0;
        #1;
        check("t6_outputs_in_rst", all_outs(), 64'h0);
        CONTROL_EN = 1'b0;
        long_at    = -1;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        clear_logs();
        start_run();
        wait_done("t6", 200);
        check("t6_rd_addrs", pack_rd(), 16'h0123);
        check("t6_tx_count", tx_q.size(), 2);
        if (tx_q.size() == 2) check("t6_tx_lo", tx_q[0], 8'h19);
        finish_run();
        check("t6_done_count", n_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
